// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: a WIDTH-bit carry chain split into
// STAGES registered chunks, with a global-stall valid/ready stream on both sides.
module pipe_rca_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic adv_s;

    assign adv_s    = ~(out_valid & ~out_ready);
    assign in_ready = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // UP: operand bits not yet consumed on entry; DONE: result bits after this stage.
        localparam int UP   = WIDTH - k * CHUNK;
        localparam int DONE = (k + 1) * CHUNK;

        logic [UP-1:0]    a_up_s;
        logic [UP-1:0]    b_up_s;
        logic             carry_in_s;
        logic             sub_in_s;
        logic             vld_in_s;
        logic [DONE-1:0]  res_in_s;
        logic [CHUNK-1:0] b_eff_s;
        logic [CHUNK:0]   chunk_sum_s;
        logic             load_s;

        logic             vld_d;
        logic             vld_q;
        logic             carry_d;
        logic             carry_q;
        logic [DONE-1:0]  res_d;
        logic [DONE-1:0]  res_q;

        if (k == 0) begin : g_src
            assign a_up_s     = a;
            assign b_up_s     = b;
            assign sub_in_s   = sub;
            // Subtract runs as a + ~b + !cin, so the borrow-in flips here.
            assign carry_in_s = cin ^ sub;
            assign vld_in_s   = in_valid;
            assign res_in_s   = chunk_sum_s[CHUNK-1:0];
        end else begin : g_src
            assign a_up_s     = g_stage[k-1].g_fwd.a_rem_q;
            assign b_up_s     = g_stage[k-1].g_fwd.b_rem_q;
            assign sub_in_s   = g_stage[k-1].g_fwd.sub_q;
            assign carry_in_s = g_stage[k-1].carry_q;
            assign vld_in_s   = g_stage[k-1].vld_q;
            assign res_in_s   = {chunk_sum_s[CHUNK-1:0], g_stage[k-1].res_q};
        end

        assign b_eff_s     = b_up_s[CHUNK-1:0] ^ {CHUNK{sub_in_s}};
        assign chunk_sum_s = {1'b0, a_up_s[CHUNK-1:0]} + {1'b0, b_eff_s}
                           + {{CHUNK{1'b0}}, carry_in_s};
        assign load_s      = adv_s & vld_in_s;

        // Valid advances on every free cycle; data loads only for real beats so bubbles keep it.
        always_comb begin
            vld_d   = vld_q;
            carry_d = carry_q;
            res_d   = res_q;
            if (adv_s) begin
                vld_d = vld_in_s;
            end else begin
                vld_d = vld_q;
            end
            if (load_s) begin
                carry_d = chunk_sum_s[CHUNK];
                res_d   = res_in_s;
            end else begin
                carry_d = carry_q;
                res_d   = res_q;
            end
        end

        // Stage valid, chunk carry and accumulated result registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else begin
                vld_q   <= vld_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UP-CHUNK-1:0] a_rem_d;
            logic [UP-CHUNK-1:0] a_rem_q;
            logic [UP-CHUNK-1:0] b_rem_d;
            logic [UP-CHUNK-1:0] b_rem_q;
            logic                sub_d;
            logic                sub_q;

            // Skew the unconsumed operand bits and the mode forward with the beat.
            always_comb begin
                a_rem_d = a_rem_q;
                b_rem_d = b_rem_q;
                sub_d   = sub_q;
                if (load_s) begin
                    a_rem_d = a_up_s[UP-1:CHUNK];
                    b_rem_d = b_up_s[UP-1:CHUNK];
                    sub_d   = sub_in_s;
                end else begin
                    a_rem_d = a_rem_q;
                    b_rem_d = b_rem_q;
                    sub_d   = sub_q;
                end
            end

            // Skewed operand registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                    sub_q   <= 1'b0;
                end else begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                    sub_q   <= sub_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_comb begin
                ovf_d = ovf_q;
                if (load_s) begin
                    ovf_d = a_up_s[CHUNK-1] ^ b_eff_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1]
                          ^ chunk_sum_s[CHUNK];
                end else begin
                    ovf_d = ovf_q;
                end
            end

            // Signed-overflow output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipe_rca_addsub.md
Name: pipe_rca_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 4-bit combinational RCA.
- Splits a WIDTH-bit carry chain into STAGES registered chunks, so wide adds close timing at high clock rates.
- Adds a subtract mode, signed-overflow detection and a valid/ready stream handshake on both sides.
- Sits between operand-producing datapath logic and any ready/valid result consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES, minimum 4.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add); NOT-borrow (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Add mode: {cout,sum} = a + b + cin.
- Subtract mode: internally a + ~b + !cin, so sum = a - b - cin mod 2^WIDTH.
  - cout = 1 means no borrow; cout = 0 means borrow.
- ovf = carry into MSB XOR carry out of MSB, valid in both modes.
- Pipeline:
  - Stage k (0..STAGES-1) adds operand chunk k plus the registered carry from stage k-1; stage 0 uses the effective carry-in.
  - Unconsumed upper operand chunks are skewed forward through registers.
  - Completed lower result chunks are delayed so that all chunks align at the output.
  - sub is carried with the beat.
- Valid tracking: each stage holds a valid bit; bubbles propagate as invalid stages and are not collapsed.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - When stall = 1, every stage register holds its value.
  - When stall = 0, all stages advance one position.
- A beat is accepted when in_valid & in_ready. A cycle with in_ready = 1 and in_valid = 0 inserts a bubble.
- Latency: the result for a beat accepted at edge N is visible on out_valid/sum/cout/ovf after edge N+STAGES-1, provided there are no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle when out_ready is held high.
- Output hold: while out_valid = 1 and out_ready = 0, sum/cout/ovf are stable.
- Ordering: results leave in acceptance order; none dropped or duplicated.
- STAGES = 1: full-width combinational add into one output register; latency 1 cycle, same handshake.
- Reset (rst_n low, asynchronous):
  - All valid bits clear; out_valid = 0; sum = 0, cout = 0, ovf = 0.
  - All datapath registers clear.
  - in_ready = 1 while in reset, since out_valid = 0.
  - Assertion mid-operation flushes every in-flight beat. No pre-reset result may appear after release.
- Boundary cases:
  - Carry propagating across every chunk boundary (e.g. all-ones + 1) must be exact.
  - in_valid asserted while stalled: the beat is not accepted; the source must hold it.
  - out_ready rising in the same cycle a new beat is offered: both the output transfer and the input acceptance occur.
- Outputs are undefined-free: when out_valid = 0, sum/cout/ovf hold their last value (0 after reset).

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
1. a=0x0000, b=0x0000, cin=0, sub=0 -> out_valid high 4 cycles after accept; sum=0x0000, cout=0, ovf=0.
2. Full carry ripple across all chunks:
   - a=0xFFFF, b=0x0001, cin=0, add -> sum=0x0000, cout=1, ovf=0.
   - a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
3. Overflow and subtract:
   - a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1.
   - sub: 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
   - sub: 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
   - sub: 0x0009-0x0006, cin=1 -> sum=0x0002, cout=1.
4. Streaming with backpressure:
   - Stimulus: 10 back-to-back beats; out_ready low for 3 cycles mid-stream.
   - Required: in_ready low exactly while stalled; results in order; outputs stable during the stall; none lost or duplicated.
5. Bubbles: in_valid pattern 1,0,1,1,0,1 -> out_valid reproduces the same pattern delayed 4 cycles, with matching results.
6. Reset and regression:
   - Assert rst_n=0 with 3 beats in flight -> out_valid=0 and sum=0 immediately; no stale results after release; the next beat completes with latency 4.
   - Repeat a random 1000-beat run against an integer reference model for STAGES=1, 2 and 16.
